// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage and its MEM/WB pipeline register.
// Contents:
//   DATA_W / REG_W  - data path and register-index widths
//   state_t         - access FSM encoding (IDLE = 0, WAIT = 1)
//   wb_fields_t     - everything the W stage receives from M
//   req_latch_t     - request and M-stage control captured when an access stalls
//   WB_BUBBLE       - all-zero W contents; never writes a register or raises a syscall
package memory_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] instruction;
        logic              syscall;
    } wb_fields_t;

    typedef struct packed {
        logic              we;
        logic              mem_read;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] instruction;
        logic              syscall;
    } req_latch_t;

    localparam wb_fields_t WB_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst_n - pipeline clock, asynchronous active-low reset
//   bubble     - load WB_BUBBLE instead of d this edge
//   d          - W-stage fields computed by the memory stage
//   q          - registered W-stage fields
module mem_wb_reg
    import memory_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble,
    input  wb_fields_t d,
    output wb_fields_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= WB_BUBBLE;
        end else if (bubble) begin
            q <= WB_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage plus MEM/WB register.
// Issues word loads/stores to a variable-latency memory over a req/ready
// handshake, stalls F/D/E/M while an access is outstanding, aborts an access
// that waits too long, and feeds the W stage (bubbles while stalled).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   ValidM..syscallM           - EX/MEM control and data
//   mem_req/we/addr/wdata      - memory request side
//   mem_ready, mem_rdata       - memory completion and load data
//   StallM                     - hold upstream stages
//   ALUOutM_forwarded          - combinational ALUOutM for forwarding
//   RegWriteW..syscallW        - registered W-stage outputs
//   misaligned, mem_timeout    - sticky error flags
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              MemToRegM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic [DATA_W-1:0] instructionM,
    input  logic              syscallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              StallM,
    output logic [DATA_W-1:0] ALUOutM_forwarded,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic [DATA_W-1:0] instructionW,
    output logic              syscallW,
    output logic              misaligned,
    output logic              mem_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    req_latch_t       req_reg;
    logic             misaligned_reg;
    logic             timeout_reg;

    logic       mem_op, aligned, access, misaligned_op, timeout_hit;
    logic       req_int, stall_int, wb_bubble;
    wb_fields_t wb_d, wb_q;

    assign mem_op        = ValidM & (MemReadM | MemWriteM);
    assign aligned       = (ALUOutM[1:0] == 2'b00);
    assign access        = mem_op & aligned;
    assign misaligned_op = mem_op & ~aligned;
    assign timeout_hit   = (state_reg == WAIT) & ~mem_ready & (cnt_reg == CNT_LAST);

    // State register, wait counter, request latch and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            req_reg        <= '0;
            misaligned_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Held at zero in IDLE so every WAIT starts counting from 0.
            if (state_reg == IDLE) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == IDLE && access && !mem_ready) begin
                req_reg <= '{we: MemWriteM, mem_read: MemReadM, addr: ALUOutM,
                             wdata: WriteDataM, reg_write: RegWriteM,
                             mem_to_reg: MemToRegM, write_reg: WriteRegM,
                             instruction: instructionM, syscall: syscallM};
            end
            if (state_reg == IDLE && misaligned_op) begin
                misaligned_reg <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (access && !mem_ready) state_next = WAIT;
            WAIT: if (mem_ready || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory request, stall and the value presented to W.
    always_comb begin
        req_int   = 1'b0;
        mem_we    = MemWriteM;
        mem_addr  = ALUOutM;
        mem_wdata = WriteDataM;
        stall_int = 1'b0;
        wb_bubble = 1'b1;
        wb_d      = WB_BUBBLE;
        case (state_reg)
            IDLE: begin
                req_int   = access;
                stall_int = access & ~mem_ready;
                // Misaligned memory ops never retire; they enter W as a bubble.
                if (ValidM && !misaligned_op && !stall_int) begin
                    wb_bubble = 1'b0;
                    wb_d = '{reg_write: RegWriteM, mem_to_reg: MemToRegM,
                             read_data: MemReadM ? mem_rdata : '0,
                             alu_out: ALUOutM, write_reg: WriteRegM,
                             instruction: instructionM, syscall: syscallM};
                end
            end
            WAIT: begin
                req_int   = 1'b1;
                mem_we    = req_reg.we;
                mem_addr  = req_reg.addr;
                mem_wdata = req_reg.wdata;
                stall_int = ~mem_ready & ~timeout_hit;
                // A completed access retires; a timed-out load retires with
                // ERR_DATA; a timed-out store is dropped.
                if (mem_ready || req_reg.mem_read) begin
                    wb_bubble = stall_int;
                end
                wb_d = '{reg_write: req_reg.reg_write, mem_to_reg: req_reg.mem_to_reg,
                         read_data: !req_reg.mem_read ? '0 :
                                    (mem_ready ? mem_rdata : ERR_DATA),
                         alu_out: req_reg.addr, write_reg: req_reg.write_reg,
                         instruction: req_reg.instruction, syscall: req_reg.syscall};
            end
            default: begin
                req_int = 1'b0;
            end
        endcase
    end

    // Gated by rst_n so an asserted reset drops the request and stall at once,
    // even while the M inputs still describe an access.
    assign mem_req = req_int & rst_n;
    assign StallM  = stall_int & rst_n;

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign ALUOutM_forwarded = ALUOutM;
    assign RegWriteW         = wb_q.reg_write;
    assign MemToRegW         = wb_q.mem_to_reg;
    assign ReadDataW         = wb_q.read_data;
    assign ALUOutW           = wb_q.alu_out;
    assign WriteRegW         = wb_q.write_reg;
    assign instructionW      = wb_q.instruction;
    assign syscallW          = wb_q.syscall;
    assign misaligned        = misaligned_reg;
    assign mem_timeout       = timeout_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage. Stimulus pushes the expected W-stage contents
// into a scoreboard queue; a monitor pops and compares each non-bubble W cycle
// (instructionW != 0). Stall, request and flag behaviour is checked inline.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, RegWriteM, MemToRegM, MemReadM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM, instructionM;
    logic [4:0]  WriteRegM;
    logic        syscallM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        StallM;
    logic [31:0] ALUOutM_forwarded;
    logic        RegWriteW, MemToRegW;
    logic [31:0] ReadDataW, ALUOutW, instructionW;
    logic [4:0]  WriteRegW;
    logic        syscallW, misaligned, mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [103:0] sb[$];

    memory_stage dut (
        .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .MemToRegM(MemToRegM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .instructionM(instructionM), .syscallM(syscallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .StallM(StallM), .ALUOutM_forwarded(ALUOutM_forwarded),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .instructionW(instructionW),
        .syscallW(syscallW), .misaligned(misaligned), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] exp_w(logic rw, logic m2r, logic [31:0] rd,
                                           logic [31:0] alu, logic [4:0] wr,
                                           logic [31:0] ins, logic sc);
        return {rw, m2r, rd, alu, wr, ins, sc};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ValidM = 0; RegWriteM = 0; MemToRegM = 0; MemReadM = 0; MemWriteM = 0;
        ALUOutM = 0; WriteDataM = 0; WriteRegM = 0; instructionM = 0; syscallM = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic set_op(logic rw, logic m2r, logic mr, logic mw, logic [31:0] alu,
                          logic [31:0] wd, logic [4:0] wr, logic [31:0] ins, logic sc);
        ValidM = 1; RegWriteM = rw; MemToRegM = m2r; MemReadM = mr; MemWriteM = mw;
        ALUOutM = alu; WriteDataM = wd; WriteRegM = wr; instructionM = ins; syscallM = sc;
    endtask

    // Monitor: every non-bubble W cycle must match the oldest expected entry.
    always @(negedge clk) begin
        logic [103:0] act;
        logic [103:0] exp;
        if (rst_n === 1'b1 && instructionW !== 32'h0) begin
            act = {RegWriteW, MemToRegW, ReadDataW, ALUOutW, WriteRegW, instructionW, syscallW};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL w_unexpected: got %026h expected no retirement", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL w_stage: got %026h expected %026h", act, exp);
                end else begin
                    $display("ok   w_stage instr 0x%08h", instructionW);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  stall_cnt;
        bit  released;
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_RegWriteW", 32'(RegWriteW), 0);
        chk("rst_ReadDataW", ReadDataW, 0);
        chk("rst_ALUOutW", ALUOutW, 0);
        chk("rst_instructionW", instructionW, 0);
        chk("rst_flags", {30'd0, misaligned, mem_timeout}, 0);
        chk("rst_req_stall", {30'd0, mem_req, StallM}, 0);
        rst_n = 1;
        step();

        // ALU op: latency 1, no memory request.
        set_op(1, 0, 0, 0, 32'h10, 0, 5'd5, 32'h11, 0);
        sb.push_back(exp_w(1, 0, 0, 32'h10, 5'd5, 32'h11, 0));
        @(negedge clk);
        chk("alu_mem_req", 32'(mem_req), 0);
        chk("alu_stall", 32'(StallM), 0);
        chk("alu_forward", ALUOutM_forwarded, 32'h10);
        step(); idle_inputs();
        @(negedge clk);
        chk("alu_mem_req_after", 32'(mem_req), 0);
        step();

        // Zero-wait load.
        set_op(1, 1, 1, 0, 32'h100, 0, 5'd7, 32'h22, 0);
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        sb.push_back(exp_w(1, 1, 32'hCAFEF00D, 32'h100, 5'd7, 32'h22, 0));
        @(negedge clk);
        chk("ld0_req", 32'(mem_req), 1);
        chk("ld0_we", 32'(mem_we), 0);
        chk("ld0_addr", mem_addr, 32'h100);
        chk("ld0_stall", 32'(StallM), 0);
        step(); idle_inputs();
        step();

        // Store completing on the fourth cycle: three stall cycles.
        set_op(0, 0, 0, 1, 32'h200, 32'h1234, 5'd0, 32'h33, 0);
        sb.push_back(exp_w(0, 0, 0, 32'h200, 5'd0, 32'h33, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("st_stall_c%0d", i), 32'(StallM), 1);
            chk($sformatf("st_req_c%0d", i), {mem_req, mem_we, 30'd0}, 32'hC000_0000);
            chk($sformatf("st_addr_c%0d", i), mem_addr, 32'h200);
            chk($sformatf("st_wdata_c%0d", i), mem_wdata, 32'h1234);
            step();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("st_done_stall", 32'(StallM), 0);
        chk("st_done_addr", mem_addr, 32'h200);
        step();

        // Back-to-back load right after WAIT completion.
        set_op(1, 1, 1, 0, 32'h300, 0, 5'd8, 32'h44, 0);
        mem_ready = 1; mem_rdata = 32'h11112222;
        sb.push_back(exp_w(1, 1, 32'h11112222, 32'h300, 5'd8, 32'h44, 0));
        @(negedge clk);
        chk("b2b_req", 32'(mem_req), 1);
        chk("b2b_addr", mem_addr, 32'h300);
        chk("b2b_stall", 32'(StallM), 0);
        step(); idle_inputs();
        step();

        // Misaligned load: no request, sticky flag, bubble in W.
        chk("mis_before", 32'(misaligned), 0);
        set_op(1, 1, 1, 0, 32'h103, 0, 5'd9, 32'h55, 0);
        mem_ready = 1; mem_rdata = 32'h99999999;
        @(negedge clk);
        chk("mis_req", 32'(mem_req), 0);
        chk("mis_stall", 32'(StallM), 0);
        step(); idle_inputs();
        @(negedge clk);
        chk("mis_flag", 32'(misaligned), 1);
        repeat (3) step();
        @(negedge clk);
        chk("mis_sticky", 32'(misaligned), 1);
        step();

        // Load that never completes: 64 stall cycles then abort.
        set_op(1, 1, 1, 0, 32'h400, 0, 5'd10, 32'h66, 0);
        stall_cnt = 0;
        released  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!StallM) begin
                released = 1;
                break;
            end
            stall_cnt++;
            step();
        end
        chk("to_released", 32'(released), 1);
        if (released) begin
            sb.push_back(exp_w(1, 1, 32'hDEADBEEF, 32'h400, 5'd10, 32'h66, 0));
            chk("to_stall_cycles", 32'(stall_cnt), 64);
            chk("to_flag_before", 32'(mem_timeout), 0);
        end
        step(); idle_inputs();
        @(negedge clk);
        chk("to_flag", 32'(mem_timeout), 1);
        chk("to_stall_after", 32'(StallM), 0);
        step();

        // Asynchronous reset in the middle of a WAIT.
        set_op(1, 1, 1, 0, 32'h500, 0, 5'd11, 32'h77, 0);
        step(); step();
        #2;
        chk("rs_req_before", {30'd0, mem_req, StallM}, 3);
        rst_n = 0;
        #1;
        chk("rs_req_stall", {30'd0, mem_req, StallM}, 0);
        chk("rs_W", {RegWriteW, MemToRegW, syscallW, 24'd0, WriteRegW}, 0);
        chk("rs_W_data", ReadDataW | ALUOutW | instructionW, 0);
        chk("rs_flags", {30'd0, misaligned, mem_timeout}, 0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
        step();
        set_op(1, 0, 0, 0, 32'h20, 0, 5'd3, 32'h88, 1);
        sb.push_back(exp_w(1, 0, 0, 32'h20, 5'd3, 32'h88, 1));
        @(negedge clk);
        chk("rs_idle_req", {30'd0, mem_req, StallM}, 0);
        step(); idle_inputs();
        repeat (3) step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
